// File: rtl/dsp48a1_mac_sequencer_pkg.sv
// rtl/dsp48a1_mac_sequencer_pkg.sv - OPMODE field encodings and FSM states for the MAC sequencer
package dsp48a1_mac_sequencer_pkg;

  localparam logic [1:0] X_ZERO = 2'b00;
  localparam logic [1:0] X_M    = 2'b01;
  localparam logic [1:0] Z_ZERO = 2'b00;
  localparam logic [1:0] Z_P    = 2'b10;
  localparam logic [1:0] Z_C    = 2'b11;

  localparam logic [3:0] OPM_FIRST   = {Z_ZERO, X_M};
  localparam logic [3:0] OPM_FIRST_C = {Z_C, X_M};
  localparam logic [3:0] OPM_ACC     = {Z_P, X_M};
  localparam logic [3:0] OPM_HOLD_P  = {Z_P, X_ZERO};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  function automatic logic [3:0] term_opmode(input logic first, input logic use_c);
    if (!first) return OPM_ACC;
    return use_c ? OPM_FIRST_C : OPM_FIRST;
  endfunction

endpackage

// File: rtl/dsp48a1_mac_sequencer_skew.sv
// rtl/dsp48a1_mac_sequencer_skew.sv - OPMODE[3:0] delay line, advances only with the slice clock enable
module dsp48a1_mac_sequencer_skew #(
  parameter int DEPTH = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       en_i,
  input  logic [3:0] d_i,
  output logic [3:0] q_o
);

  logic [3:0] stage_q [DEPTH];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= 4'b0000;
    end else if (en_i) begin
      stage_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/dsp48a1_mac_sequencer.sv
// rtl/dsp48a1_mac_sequencer.sv - drives one DSP48A1 slice through N-term multiply-accumulate jobs
module dsp48a1_mac_sequencer
  import dsp48a1_mac_sequencer_pkg::*;
#(
  parameter int LEN_W    = 8,
  parameter int PIPE_LAT = 3,
  parameter int OP_SKEW  = 2
) (
  input  logic              clk,
  input  logic              RST,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              cmd_preadd,
  input  logic              cmd_sub,
  input  logic              cmd_use_c,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [17:0]       op_a,
  input  logic [17:0]       op_b,
  input  logic [17:0]       op_d,
  output logic [17:0]       dsp_a,
  output logic [17:0]       dsp_b,
  output logic [17:0]       dsp_d,
  output logic [7:0]        dsp_opmode,
  output logic              dsp_ce,
  output logic              dsp_cec,
  output logic              dsp_rst,
  input  logic [47:0]       dsp_p,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [47:0]       res_data,
  output logic              err_len0
);

  // Slice steps lag the issue handshake by one cycle because dsp_ce is registered.
  localparam int DRAIN_LAST = PIPE_LAT + OP_SKEW + 1;
  localparam int DRAIN_W    = $clog2(DRAIN_LAST + 1);

  state_e             state_q, state_d;
  logic [LEN_W-1:0]   len_q;
  logic               preadd_q, sub_q, use_c_q;
  logic [LEN_W-1:0]   term_cnt_q, term_cnt_d;
  logic [DRAIN_W-1:0] drain_cnt_q, drain_cnt_d;
  logic [3:0]         issue_op_q, issue_op_d;
  logic [17:0]        dsp_a_q, dsp_b_q, dsp_d_q;
  logic               dsp_ce_q, dsp_ce_d;
  logic               dsp_cec_q, dsp_cec_d;
  logic               dsp_rst_q;
  logic               res_valid_q, res_valid_d;
  logic [47:0]        res_data_q, res_data_d;
  logic               err_len0_q, err_len0_d;
  logic               load_cmd, load_op;
  logic               cmd_fire, op_fire;
  logic [3:0]         skew_op;

  assign cmd_ready = (state_q == ST_IDLE) && !dsp_rst_q;
  assign op_ready  = (state_q == ST_ISSUE);
  assign cmd_fire  = cmd_valid && cmd_ready;
  assign op_fire   = op_valid && op_ready;

  always_comb begin
    state_d     = state_q;
    term_cnt_d  = term_cnt_q;
    drain_cnt_d = drain_cnt_q;
    issue_op_d  = issue_op_q;
    dsp_ce_d    = 1'b0;
    dsp_cec_d   = 1'b0;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    err_len0_d  = 1'b0;
    load_cmd    = 1'b0;
    load_op     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_fire) begin
          if (cmd_len == '0) begin
            err_len0_d = 1'b1;
          end else begin
            load_cmd   = 1'b1;
            term_cnt_d = '0;
            state_d    = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        if (op_fire) begin
          load_op    = 1'b1;
          dsp_ce_d   = 1'b1;
          dsp_cec_d  = use_c_q && (term_cnt_q == '0);
          issue_op_d = term_opmode(term_cnt_q == '0, use_c_q);
          term_cnt_d = term_cnt_q + LEN_W'(1);
          if (term_cnt_q == len_q - LEN_W'(1)) begin
            state_d     = ST_DRAIN;
            drain_cnt_d = '0;
          end
        end
      end
      ST_DRAIN: begin
        issue_op_d = OPM_HOLD_P;
        if (drain_cnt_q == DRAIN_W'(DRAIN_LAST)) begin
          res_valid_d = 1'b1;
          res_data_d  = dsp_p;
          state_d     = ST_DONE;
        end else begin
          dsp_ce_d    = 1'b1;
          drain_cnt_d = drain_cnt_q + DRAIN_W'(1);
        end
      end
      ST_DONE: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      len_q       <= '0;
      preadd_q    <= 1'b0;
      sub_q       <= 1'b0;
      use_c_q     <= 1'b0;
      term_cnt_q  <= '0;
      drain_cnt_q <= '0;
      issue_op_q  <= 4'b0000;
      dsp_a_q     <= '0;
      dsp_b_q     <= '0;
      dsp_d_q     <= '0;
      dsp_ce_q    <= 1'b0;
      dsp_cec_q   <= 1'b0;
      dsp_rst_q   <= 1'b1;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      err_len0_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      term_cnt_q  <= term_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      issue_op_q  <= issue_op_d;
      dsp_ce_q    <= dsp_ce_d;
      dsp_cec_q   <= dsp_cec_d;
      dsp_rst_q   <= 1'b0;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      err_len0_q  <= err_len0_d;
      if (load_cmd) begin
        len_q    <= cmd_len;
        preadd_q <= cmd_preadd;
        sub_q    <= cmd_sub;
        use_c_q  <= cmd_use_c;
      end
      if (load_op) begin
        dsp_a_q <= op_a;
        dsp_b_q <= op_b;
        dsp_d_q <= op_d;
      end
    end
  end

  dsp48a1_mac_sequencer_skew #(
    .DEPTH (OP_SKEW)
  ) u_skew (
    .clk_i (clk),
    .rst_i (RST),
    .en_i  (dsp_ce_q),
    .d_i   (issue_op_q),
    .q_o   (skew_op)
  );

  assign dsp_a      = dsp_a_q;
  assign dsp_b      = dsp_b_q;
  assign dsp_d      = dsp_d_q;
  assign dsp_opmode = {1'b0, sub_q, 1'b0, preadd_q, skew_op};
  assign dsp_ce     = dsp_ce_q;
  assign dsp_cec    = dsp_cec_q;
  assign dsp_rst    = dsp_rst_q;
  assign res_valid  = res_valid_q;
  assign res_data   = res_data_q;
  assign err_len0   = err_len0_q;

endmodule

// File: tb/tb_dsp48a1_mac_sequencer.sv
// tb/tb_dsp48a1_mac_sequencer.sv - scoreboard bench with a behavioural DSP48A1 slice and software MAC reference
module tb_dsp48a1_mac_sequencer;

  localparam int PERIOD   = 10;
  localparam int HALF     = 5;
  localparam int LEN_W    = 8;
  localparam int PIPE_LAT = 3;
  localparam int OP_SKEW  = 2;

  logic             clk, RST;
  logic             cmd_valid, cmd_ready, cmd_preadd, cmd_sub, cmd_use_c;
  logic [LEN_W-1:0] cmd_len;
  logic             op_valid, op_ready;
  logic [17:0]      op_a, op_b, op_d;
  logic [17:0]      dsp_a, dsp_b, dsp_d;
  logic [7:0]       dsp_opmode;
  logic             dsp_ce, dsp_cec, dsp_rst;
  logic [47:0]      dsp_p;
  logic             res_valid, res_ready;
  logic [47:0]      res_data;
  logic             err_len0;

  dsp48a1_mac_sequencer #(
    .LEN_W(LEN_W), .PIPE_LAT(PIPE_LAT), .OP_SKEW(OP_SKEW)
  ) dut (
    .clk(clk), .RST(RST),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
    .cmd_preadd(cmd_preadd), .cmd_sub(cmd_sub), .cmd_use_c(cmd_use_c),
    .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b), .op_d(op_d),
    .dsp_a(dsp_a), .dsp_b(dsp_b), .dsp_d(dsp_d), .dsp_opmode(dsp_opmode),
    .dsp_ce(dsp_ce), .dsp_cec(dsp_cec), .dsp_rst(dsp_rst), .dsp_p(dsp_p),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .err_len0(err_len0)
  );

  initial clk = 1'b0;
  always #HALF clk = ~clk;

  // Slice model: stage-1 regs with pre-adder, M reg, P reg; OPMODE[3:0] used as presented.
  logic signed [17:0] s_a1, s_b1, pre_b;
  logic signed [47:0] s_m, s_p, s_c, x_mux, z_mux;
  logic [47:0]        c_in;

  always_comb begin
    pre_b = dsp_b;
    if (dsp_opmode[4]) pre_b = dsp_opmode[6] ? dsp_d - dsp_b : dsp_d + dsp_b;
    x_mux = '0;
    if (dsp_opmode[1:0] == 2'b01) x_mux = s_m;
    else if (dsp_opmode[1:0] == 2'b10) x_mux = s_p;
    z_mux = '0;
    if (dsp_opmode[3:2] == 2'b10) z_mux = s_p;
    else if (dsp_opmode[3:2] == 2'b11) z_mux = s_c;
  end

  always @(posedge clk) begin
    if (dsp_rst) begin
      s_a1 <= '0; s_b1 <= '0; s_m <= '0; s_p <= '0; s_c <= '0;
    end else begin
      if (dsp_cec) s_c <= c_in;
      if (dsp_ce) begin
        s_a1 <= dsp_a;
        s_b1 <= pre_b;
        s_m  <= s_a1 * s_b1;
        s_p  <= x_mux + z_mux;
      end
    end
  end
  assign dsp_p = s_p;

  typedef struct {
    logic [47:0] data;
    int          lat;
    longint      acc_t;
  } exp_t;
  exp_t exp_q[$];

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  logic signed [17:0] ja [256];
  logic signed [17:0] jb [256];
  logic signed [17:0] jd [256];
  int                 jstall [256];

  function automatic logic [47:0] ref_sum(input int len, input bit pre, input bit sub,
                                          input bit usec, input logic [47:0] c);
    logic signed [47:0] acc;
    logic signed [17:0] bm;
    acc = '0;
    if (usec) acc = c;
    for (int i = 0; i < len; i++) begin
      if (!pre) bm = jb[i];
      else if (sub) bm = jd[i] - jb[i];
      else bm = jd[i] + jb[i];
      acc = acc + ja[i] * bm;
    end
    return acc;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_job();
    for (int i = 0; i < 256; i++) begin
      ja[i] = '0; jb[i] = '0; jd[i] = '0; jstall[i] = 0;
    end
  endtask

  task automatic run_job(input int len, input bit pre, input bit sub, input bit usec,
                         input logic [47:0] c, input int hold);
    exp_t e;
    int   n, stalls;
    stalls = 0;
    for (int i = 0; i < len; i++) stalls += jstall[i];
    c_in       = c;
    cmd_len    = LEN_W'(len);
    cmd_preadd = pre;
    cmd_sub    = sub;
    cmd_use_c  = usec;
    cmd_valid  = 1'b1;
    n = 0;
    while (!cmd_ready && n < 50) begin tick(); n++; end
    if (!cmd_ready) begin
      chk("cmd_accept_timeout", 0, 1);
      cmd_valid = 1'b0;
      return;
    end
    e.data  = ref_sum(len, pre, sub, usec, c);
    e.lat   = len + PIPE_LAT + OP_SKEW + 2 + stalls;
    e.acc_t = longint'($time) - 1 + PERIOD;
    exp_q.push_back(e);
    tick();
    cmd_valid = 1'b0;
    for (int i = 0; i < len; i++) begin
      for (int s = 0; s < jstall[i]; s++) begin op_valid = 1'b0; tick(); end
      op_valid = 1'b1;
      op_a = ja[i]; op_b = jb[i]; op_d = jd[i];
      n = 0;
      while (!op_ready && n < 50) begin tick(); n++; end
      if (!op_ready) begin
        chk("op_ready_timeout", 0, 1);
        op_valid = 1'b0;
        return;
      end
      tick();
    end
    op_valid = 1'b0;
    n = 0;
    while (!res_valid && n < 100) begin tick(); n++; end
    if (!res_valid) begin
      chk("res_valid_timeout", 0, 1);
      return;
    end
    for (int h = 0; h < hold; h++) begin
      chk("cmd_ready_while_held", cmd_ready, 0);
      tick();
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("res_valid_after_accept", res_valid, 0);
    chk("cmd_ready_after_accept", cmd_ready, 1);
  endtask

  // Monitor: latency at the rising edge of res_valid, data at every held and accepting cycle.
  exp_t cur;
  bit   have_cur = 0;
  logic prev_rv  = 1'b0;
  always @(negedge clk) begin
    if (res_valid && !prev_rv) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_result", 1, 0);
      end else begin
        cur = exp_q.pop_front();
        have_cur = 1;
        chk("latency", 64'(($time - HALF - cur.acc_t) / PERIOD), 64'(cur.lat));
        chk("cmd_ready_in_done", cmd_ready, 0);
      end
    end
    if (res_valid && have_cur && !res_ready) chk("res_data_hold", res_data, cur.data);
    if (res_valid && have_cur && res_ready) begin
      chk("res_data", res_data, cur.data);
      have_cur = 0;
    end
    prev_rv = res_valid;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, %0d vectors applied", n_vec);
    $fatal(1, "watchdog");
  end

  initial begin
    int          len;
    bit          pre, sub, usec;
    logic [47:0] c;
    RST = 1'b1;
    cmd_valid = 0; cmd_len = '0; cmd_preadd = 0; cmd_sub = 0; cmd_use_c = 0;
    op_valid = 0; op_a = '0; op_b = '0; op_d = '0; res_ready = 0; c_in = '0;
    clear_job();

    @(negedge clk); @(negedge clk);
    chk("reset_ctrl", {cmd_ready, op_ready, res_valid, dsp_ce, dsp_cec, err_len0, dsp_opmode}, 0);
    chk("reset_res_data", res_data, 0);
    chk("reset_dsp_a", dsp_a, 0);
    chk("reset_dsp_rst", dsp_rst, 1);
    @(posedge clk); #1 RST = 1'b0;
    @(negedge clk);
    chk("dsp_rst_after_release", dsp_rst, 1);
    chk("cmd_ready_after_release", cmd_ready, 0);
    tick();
    chk("dsp_rst_cleared", dsp_rst, 0);
    chk("cmd_ready_idle", cmd_ready, 1);

    // single term 3*5
    clear_job();
    ja[0] = 3; jb[0] = 5;
    run_job(1, 0, 0, 0, '0, 0);

    // pre-adder add and subtract
    for (int s = 0; s < 2; s++) begin
      clear_job();
      for (int i = 0; i < 4; i++) begin ja[i] = 18'(i + 1); jb[i] = 2; jd[i] = 10; end
      run_job(4, 1, s[0], 0, '0, 0);
    end

    // C on first term, without and with a 2-cycle operand gap
    for (int s = 0; s < 2; s++) begin
      clear_job();
      for (int i = 0; i < 3; i++) begin ja[i] = 2; jb[i] = 2; end
      if (s == 1) jstall[1] = 2;
      run_job(3, 0, 0, 1, 48'd100, 0);
    end

    // zero-length command
    tick();
    cmd_len = '0; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    chk("err_len0_pulse", err_len0, 1);
    chk("len0_cmd_ready", cmd_ready, 1);
    chk("len0_no_ce", dsp_ce, 0);
    tick();
    chk("err_len0_single", err_len0, 0);
    chk("len0_cmd_ready_after", cmd_ready, 1);
    chk("len0_no_ce_after", dsp_ce, 0);

    // result held five cycles
    clear_job();
    ja[0] = -7; jb[0] = 11; ja[1] = 300; jb[1] = -4;
    run_job(2, 0, 0, 0, '0, 5);

    // reset in the middle of a 4-term job
    clear_job();
    cmd_len = 4; cmd_preadd = 0; cmd_sub = 0; cmd_use_c = 0; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    op_valid = 1'b1; op_a = 18'd9; op_b = 18'd9; op_d = '0;
    tick();
    #2 RST = 1'b1;
    #1;
    chk("midjob_rst_ctrl", {cmd_ready, op_ready, res_valid, dsp_ce, dsp_cec, err_len0, dsp_opmode}, 0);
    chk("midjob_rst_dsp_a", dsp_a, 0);
    chk("midjob_rst_dsp_rst", dsp_rst, 1);
    op_valid = 1'b0;
    tick(); tick();
    RST = 1'b0;
    @(negedge clk);
    chk("midjob_dsp_rst_post", dsp_rst, 1);
    tick();
    chk("midjob_dsp_rst_clear", dsp_rst, 0);
    clear_job();
    ja[0] = 7; jb[0] = -3;
    run_job(1, 0, 0, 0, '0, 0);

    // randomized jobs
    for (int j = 0; j < 12; j++) begin
      clear_job();
      len  = $urandom_range(1, 16);
      pre  = $urandom_range(0, 1);
      sub  = $urandom_range(0, 1);
      usec = $urandom_range(0, 1);
      c    = {16'($urandom), $urandom};
      for (int i = 0; i < len; i++) begin
        ja[i] = 18'($urandom); jb[i] = 18'($urandom); jd[i] = 18'($urandom);
        jstall[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
      end
      run_job(len, pre, sub, usec, c, $urandom_range(0, 3));
    end

    // maximum length job
    clear_job();
    for (int i = 0; i < 255; i++) begin
      ja[i] = 18'($urandom); jb[i] = 18'($urandom); jd[i] = 18'($urandom);
    end
    run_job(255, 1, 1, 1, {16'($urandom), $urandom}, 1);

    repeat (4) tick();
    chk("scoreboard_empty", 64'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
